ips2l_pcie_dma_mwr_tlp_gen: RTL
===============================

Name: ips2l_pcie_dma_mwr_tlp_gen

Overview:
Memory-write TLP generator that sits directly downstream of the DMA BAR-read controller.
- Accepts one DMA write request: local RAM source address, PCIe destination address and DW length.
- Starts the read controller and consumes its 128-bit packed data stream.
- Emits complete MWr TLPs on the 128-bit AXI-Stream master port of the PCIe core, with 3DW or 4DW header and DW re-alignment.

Parameters:
- FORCE_4DW, 0: 1 = always use a 4DW header, even when dst_addr[63:32]==0.

Ports:
- clk  in  1  core user clock (gen1 62.5 MHz, gen2 125 MHz); the only clock.
- rst  in  1  reset, synchronous, active-high.
- i_mwr_req  in  1  request valid, level; held until o_mwr_ack.
- i_mwr_src_addr  in  64  local BAR RAM byte address.
- i_mwr_dst_addr  in  64  PCIe destination byte address; bits [1:0] ignored.
- i_mwr_length  in  10  payload in DW, 1..1023; 0 is illegal.
- i_req_id  in  16  requester ID.
- i_tag  in  8  tag.
- o_mwr_ack  out  1  one-cycle pulse: request accepted.
- o_mwr_done  out  1  one-cycle pulse: TLP tlast accepted.
- o_rd_en  out  1  to read ctrl; rising edge starts a read.
- o_rd_length  out  10  to read ctrl.
- o_rd_addr  out  64  to read ctrl (= src addr).
- o_tx_hold  out  1  to read ctrl (= ~i_axis_master_tready).
- o_tlp_tx  out  1  to read ctrl; pop enable in data-consuming states.
- i_gen_tlp_start  in  1  read-ctrl FIFO data valid.
- i_rd_data  in  128  read-ctrl data; DW0 in [31:0].
- i_last_data  in  1  read-ctrl last-beat pop flag.
- o_axis_master_tvalid  out  1  AXI-Stream valid to core.
- i_axis_master_tready  in  1  AXI-Stream ready from core.
- o_axis_master_tdata  out  128  TLP data.
- o_axis_master_tkeep  out  4  one bit per DW.
- o_axis_master_tlast  out  1  last beat of TLP.

Behaviour:
Reset:
- All outputs are 0, state = IDLE, carry register = 0.
- rst asserted mid-TLP: immediate return to IDLE, o_rd_en=0, and no tlast is emitted.
- rst is shared with the read ctrl, so it restarts as well.

States:
- IDLE: on i_mwr_req && length!=0:
  - latch all request fields, pulse o_mwr_ack, go to START.
  - Select 3DW if dst[63:32]==0 && !FORCE_4DW, else 4DW.
  - length==0 request: pulse o_mwr_ack and o_mwr_done in the same cycle, emit no TLP.
- START: o_rd_en=1 (held until DONE), length/addr driven from latches. Go to HDR next cycle.
- HDR, 3DW:
  - tvalid = i_gen_tlp_start; tdata = {rd[31:0], H2, H1, H0}; tkeep = F.
  - Pop on tready (o_tlp_tx=1); carry <= rd[127:32].
  - tlast when length==1 → DONE; else → DATA.
- HDR, 4DW:
  - tvalid=1; tdata = {H3, H2, H1, H0}; tkeep = F; o_tlp_tx=0 (no pop). → DATA on tready.
- DATA, 3DW:
  - tdata = {rd[31:0], carry[95:0]}; tkeep = F.
  - Pop on tready and update carry.
  - On the i_last_data pop, r = ((len-1) mod 4)+1:
    - r==1: tlast on this beat → DONE.
    - else → TAIL.
- DATA, 4DW:
  - tdata = rd; pass-through.
  - On the i_last_data beat: tlast, tkeep = (1<<r)-1 → DONE.
- TAIL (3DW only):
  - tvalid=1; tdata = {32'b0, carry[95:0]}; tkeep = (1<<(r-1))-1; tlast; o_tlp_tx=0 → DONE on tready.
- DONE: o_rd_en=0, pulse o_mwr_done → IDLE.

Header fields:
- H0 = {fmt(3DW 3'b010, 4DW 3'b011), type 5'b0, 14'b0, length}.
- H1 = {req_id, tag, lastBE, firstBE}: firstBE = F; lastBE = F, or 0 when length==1.
- H2 = 3DW: {dst[31:2], 2'b0}; 4DW: dst[63:32].
- H3 = {dst[31:2], 2'b0}.
- No byte swap.

Handshake:
- AXIS outputs are combinational from state, carry and i_rd_data. This is stable while tready=0 because no pop occurs (o_tx_hold high).
- tvalid in data states = i_gen_tlp_start; a gap in read-ctrl data inserts an idle cycle with tvalid=0.
- Pop occurs exactly when o_tlp_tx && tready && i_gen_tlp_start.
- A new request is not accepted until IDLE; back-to-back requests have a 2-cycle minimum gap (DONE, IDLE).

Decomposition:
- Package ips2l_pcie_dma_pkg holds:
  - state encoding;
  - constants FMT_MWR_3DW = 3'b010, FMT_MWR_4DW = 3'b011, TYPE_MEM = 5'b0;
  - function dw_keep(r) → 4-bit keep.
- Sub-module ips2l_pcie_dma_mwr_hdr_build: combinational H0..H3 from latched fields. Everything else stays in one FSM module.

Test Plan:
- 3DW, len=8, dst=0x0000_1000, tready=1 → 3 beats: {d0,H}, {d4,d1..d3}, tail {d5..d7} keep=7 with tlast; H0=0x40000008.
- 3DW, len=1 → single beat keep=F with tlast; H1[7:0]=0x0F; o_mwr_done one cycle after the beat.
- 4DW, dst=0x1_0000_0000, len=6 → header beat H3=0, H2=1, H0=0x60000006; data beat keep=F; last beat keep=3 with tlast.
- tready toggled 1/0 each cycle, len=16 3DW → tdata stable while tready=0; o_tx_hold mirrors ~tready; 5 beats total; no DW lost or duplicated.
- rst asserted during DATA of a len=64 TLP → next cycle all outputs 0, o_rd_en=0; a following len=4 request completes normally.
- len=0 request → ack and done in the same cycle; no tvalid; o_rd_en stays 0.

Source files
------------

// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared definitions for the DMA memory-write TLP path.
// Contents:
//   - FSM state encoding used by the MWr TLP generator
//   - TLP fmt/type constants for memory writes
//   - mwr_hdr_t, the four header DWs (h0 is sent first, in tdata[31:0])
//   - dw_keep(r), the DW keep mask for r valid DWs (0..4)
package ips2l_pcie_dma_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_HDR   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_TAIL  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [2:0] FMT_MWR_3DW = 3'b010;
  localparam logic [2:0] FMT_MWR_4DW = 3'b011;
  localparam logic [4:0] TYPE_MEM    = 5'b0;

  typedef struct packed {
    logic [31:0] h3;
    logic [31:0] h2;
    logic [31:0] h1;
    logic [31:0] h0;
  } mwr_hdr_t;

  // Keep mask with the r lowest DW lanes set.
  function automatic logic [3:0] dw_keep(input logic [2:0] r);
    logic [3:0] keep;
    case (r)
      3'd0:    keep = 4'h0;
      3'd1:    keep = 4'h1;
      3'd2:    keep = 4'h3;
      3'd3:    keep = 4'h7;
      default: keep = 4'hF;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/ips2l_pcie_dma_mwr_hdr_build.sv
// Combinational MWr TLP header builder.
// Ports:
//   use_4dw   in   1  select 4DW header (64-bit address) instead of 3DW
//   length    in  10  payload length in DW
//   req_id    in  16  requester ID
//   tag       in   8  tag
//   dst_hi    in  32  destination address bits [63:32]
//   dst_lo    in  30  destination address bits [31:2]
//   hdr       out 128 header DWs h0..h3 (h3 only meaningful for 4DW)
module ips2l_pcie_dma_mwr_hdr_build
  import ips2l_pcie_dma_pkg::*;
(
  input  logic        use_4dw,
  input  logic [9:0]  length,
  input  logic [15:0] req_id,
  input  logic [7:0]  tag,
  input  logic [31:0] dst_hi,
  input  logic [29:0] dst_lo,
  output mwr_hdr_t    hdr
);

  logic [3:0] last_be;

  always_comb begin
    // A single-DW write must carry a zero last byte enable.
    last_be = (length == 10'd1) ? 4'h0 : 4'hF;
    hdr.h0  = {(use_4dw ? FMT_MWR_4DW : FMT_MWR_3DW), TYPE_MEM, 14'b0, length};
    hdr.h1  = {req_id, tag, last_be, 4'hF};
    hdr.h2  = use_4dw ? dst_hi : {dst_lo, 2'b00};
    hdr.h3  = {dst_lo, 2'b00};
  end

endmodule

// File: rtl/ips2l_pcie_dma_mwr_tlp_gen.sv
// Memory-write TLP generator. Accepts one DMA write request, starts the
// BAR-read controller, consumes its 128-bit data stream and emits a complete
// MWr TLP on the AXI-Stream master port, with 3DW or 4DW header. With a 3DW
// header the payload is shifted by one DW (DW0 rides with the header), so
// the upper three DWs of each read beat are carried into the next beat.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_mwr_req .. i_tag           request (level, held until o_mwr_ack)
//   o_mwr_ack, o_mwr_done        one-cycle accept / completion pulses
//   o_rd_en .. o_tlp_tx          control to the read controller
//   i_gen_tlp_start, i_rd_data,
//   i_last_data                  data stream from the read controller
//   o_axis_master_*              AXI-Stream master to the PCIe core
module ips2l_pcie_dma_mwr_tlp_gen
  import ips2l_pcie_dma_pkg::*;
#(
  parameter bit FORCE_4DW = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_mwr_req,
  input  logic [63:0]  i_mwr_src_addr,
  input  logic [63:0]  i_mwr_dst_addr,
  input  logic [9:0]   i_mwr_length,
  input  logic [15:0]  i_req_id,
  input  logic [7:0]   i_tag,
  output logic         o_mwr_ack,
  output logic         o_mwr_done,
  output logic         o_rd_en,
  output logic [9:0]   o_rd_length,
  output logic [63:0]  o_rd_addr,
  output logic         o_tx_hold,
  output logic         o_tlp_tx,
  input  logic         i_gen_tlp_start,
  input  logic [127:0] i_rd_data,
  input  logic         i_last_data,
  output logic         o_axis_master_tvalid,
  input  logic         i_axis_master_tready,
  output logic [127:0] o_axis_master_tdata,
  output logic [3:0]   o_axis_master_tkeep,
  output logic         o_axis_master_tlast
);

  logic [2:0]  state_q, state_d;
  logic        use_4dw_q, use_4dw_d;
  logic [9:0]  len_q, len_d;
  logic [63:0] src_q, src_d;
  logic [61:0] dst_q, dst_d;
  logic [15:0] req_id_q, req_id_d;
  logic [7:0]  tag_q, tag_d;
  logic [95:0] carry_q, carry_d;
  logic        ack_q, ack_d;
  logic        zdone_q, zdone_d;

  logic [2:0]  rem_dw;
  mwr_hdr_t    hdr;

  // Byte offset bits of the destination are meaningless for DW writes.
  logic unused_dst_lsb;
  assign unused_dst_lsb = ^i_mwr_dst_addr[1:0];

  ips2l_pcie_dma_mwr_hdr_build u_hdr_build (
    .use_4dw (use_4dw_q),
    .length  (len_q),
    .req_id  (req_id_q),
    .tag     (tag_q),
    .dst_hi  (dst_q[61:30]),
    .dst_lo  (dst_q[29:0]),
    .hdr     (hdr)
  );

  // DWs in the final read beat: ((len-1) mod 4) + 1.
  assign rem_dw = {1'b0, len_q[1:0] - 2'd1} + 3'd1;

  assign o_rd_length = len_q;
  assign o_rd_addr   = src_q;
  assign o_tx_hold   = !i_axis_master_tready;
  assign o_mwr_ack   = ack_q;
  assign o_mwr_done  = (state_q == ST_DONE) || zdone_q;
  assign o_rd_en     = (state_q == ST_START) || (state_q == ST_HDR) ||
                       (state_q == ST_DATA)  || (state_q == ST_TAIL);

  always_comb begin
    state_d   = state_q;
    use_4dw_d = use_4dw_q;
    len_d     = len_q;
    src_d     = src_q;
    dst_d     = dst_q;
    req_id_d  = req_id_q;
    tag_d     = tag_q;
    carry_d   = carry_q;
    ack_d     = 1'b0;
    zdone_d   = 1'b0;

    o_tlp_tx             = 1'b0;
    o_axis_master_tvalid = 1'b0;
    o_axis_master_tdata  = '0;
    o_axis_master_tkeep  = 4'h0;
    o_axis_master_tlast  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ack_q guards against re-accepting the still-held request in the
        // cycle the ack pulse is visible.
        if (i_mwr_req && !ack_q) begin
          ack_d = 1'b1;
          if (i_mwr_length == 10'd0) begin
            zdone_d = 1'b1;
          end else begin
            use_4dw_d = FORCE_4DW || (i_mwr_dst_addr[63:32] != 32'd0);
            len_d     = i_mwr_length;
            src_d     = i_mwr_src_addr;
            dst_d     = i_mwr_dst_addr[63:2];
            req_id_d  = i_req_id;
            tag_d     = i_tag;
            state_d   = ST_START;
          end
        end
      end

      ST_START: begin
        state_d = ST_HDR;
      end

      ST_HDR: begin
        o_axis_master_tkeep = 4'hF;
        if (use_4dw_q) begin
          o_axis_master_tvalid = 1'b1;
          o_axis_master_tdata  = hdr;
          if (i_axis_master_tready) begin
            state_d = ST_DATA;
          end
        end else begin
          o_tlp_tx             = 1'b1;
          o_axis_master_tvalid = i_gen_tlp_start;
          o_axis_master_tdata  = {i_rd_data[31:0], hdr.h2, hdr.h1, hdr.h0};
          o_axis_master_tlast  = (len_q == 10'd1);
          if (i_axis_master_tready && i_gen_tlp_start) begin
            carry_d = i_rd_data[127:32];
            if (len_q == 10'd1) begin
              state_d = ST_DONE;
            end else if (i_last_data) begin
              // 2..4 DW payload: the only read beat went out with the header.
              state_d = ST_TAIL;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        o_tlp_tx             = 1'b1;
        o_axis_master_tvalid = i_gen_tlp_start;
        if (use_4dw_q) begin
          o_axis_master_tdata = i_rd_data;
          o_axis_master_tkeep = i_last_data ? dw_keep(rem_dw) : 4'hF;
          o_axis_master_tlast = i_gen_tlp_start && i_last_data;
          if (i_axis_master_tready && i_gen_tlp_start && i_last_data) begin
            state_d = ST_DONE;
          end
        end else begin
          o_axis_master_tdata = {i_rd_data[31:0], carry_q};
          o_axis_master_tkeep = 4'hF;
          o_axis_master_tlast = i_gen_tlp_start && i_last_data && (rem_dw == 3'd1);
          if (i_axis_master_tready && i_gen_tlp_start) begin
            carry_d = i_rd_data[127:32];
            if (i_last_data) begin
              state_d = (rem_dw == 3'd1) ? ST_DONE : ST_TAIL;
            end
          end
        end
      end

      ST_TAIL: begin
        // Flush the carried DWs; nothing is popped from the read controller.
        o_axis_master_tvalid = 1'b1;
        o_axis_master_tdata  = {32'b0, carry_q};
        o_axis_master_tkeep  = dw_keep(rem_dw - 3'd1);
        o_axis_master_tlast  = 1'b1;
        if (i_axis_master_tready) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      use_4dw_q <= 1'b0;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      req_id_q  <= '0;
      tag_q     <= '0;
      carry_q   <= '0;
      ack_q     <= 1'b0;
      zdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      use_4dw_q <= use_4dw_d;
      len_q     <= len_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      req_id_q  <= req_id_d;
      tag_q     <= tag_d;
      carry_q   <= carry_d;
      ack_q     <= ack_d;
      zdone_q   <= zdone_d;
    end
  end

endmodule
